bram_sample_buffer: RTL and testbench

- Parametrised single-clock successor to the acquisition sample BRAM controller: captures N channels of sign/magnitude samples into a simple dual-port BRAM and plays them back to the correlator core.
- Generalises channel count, sample width and depth, adds wrap-around reads with backpressure and collision reporting, and optionally adds trigger-stopped ring capture.
- Sits between the RF front-end sample stream and the acquisition core. Register mapping is done by a separate bus wrapper.

---
 rtl/bram_sample_buffer.sv | 223 ++++++++++++++++++++++
 tb/tb_bram_sample_buffer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sample_buffer.sv
// Multi-channel sample capture into a simple dual-port BRAM with wrap-around playback.
// Define BRAM_SAMPLE_BUFFER_TRIG_EN to add trigger-stopped ring capture.
module bram_sample_buffer #(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 4,
  parameter int DEPTH    = 1024,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*SAMPLE_W-1:0] din,
  input  logic                         din_we,
  input  logic                         wr_start,
  input  logic [AW:0]                  wr_len,
  output logic                         wr_busy,
  output logic                         wr_done,
  input  logic                         rd_start,
  input  logic [AW-1:0]                rd_addr,
  input  logic [AW:0]                  rd_len,
  input  logic                         rd_ready,
  output logic [CHANNELS*SAMPLE_W-1:0] dout,
  output logic                         dout_valid,
  output logic                         rd_busy,
  output logic                         rd_done,
`ifdef BRAM_SAMPLE_BUFFER_TRIG_EN
  input  logic                         trig_mode,
  input  logic                         trig,
  input  logic [AW:0]                  post_len,
  output logic [AW-1:0]                trig_addr,
`endif
  output logic                         err_reject
);

  localparam int          DATA_W  = CHANNELS * SAMPLE_W;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
    return (len > DEPTH_L) ? DEPTH_L : len;
  endfunction

  typedef enum logic [1:0] {W_IDLE, W_CAPT, W_RING} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_RUN, R_DRAIN} rstate_t;

  logic [DATA_W-1:0] mem [DEPTH];

  wstate_t             wstate_q, wstate_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]         wcnt_q, wcnt_d;
  logic                wr_done_q, wr_done_d;
  logic                mem_we;
  logic                ring_sel;
  logic [AW-1:0]       trig_addr_q, trig_addr_d;

  rstate_t             rstate_q, rstate_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         rcnt_q, rcnt_d;
  logic                rd_done_q, rd_done_d;
  logic                err_q, err_d;
  logic                rd_accept, issue;

  logic [DATA_W-1:0]   rdata_p1_q, dout_p2_q;
  logic                vld_p1_q, vld_p2_q;

`ifdef BRAM_SAMPLE_BUFFER_TRIG_EN
  assign ring_sel  = trig_mode;
  assign trig_addr = trig_addr_q;
`else
  assign ring_sel  = 1'b0;
`endif

  always_comb begin
    wstate_d    = wstate_q;
    wr_ptr_d    = wr_ptr_q;
    wcnt_d      = wcnt_q;
    wr_done_d   = wr_done_q;
    trig_addr_d = trig_addr_q;
    mem_we      = 1'b0;
    if (wr_start) begin
      // A new start always re-arms, aborting any capture in progress.
      wr_ptr_d  = '0;
      wcnt_d    = clamp_len(wr_len);
      wr_done_d = 1'b0;
      if (ring_sel) begin
        wstate_d = W_RING;
      end else if (clamp_len(wr_len) == '0) begin
        wstate_d  = W_IDLE;
        wr_done_d = 1'b1;
      end else begin
        wstate_d = W_CAPT;
      end
    end else begin
      case (wstate_q)
        W_CAPT: begin
          if (din_we) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            wcnt_d   = wcnt_q - 1'b1;
            if (wcnt_q == ONE_L) begin
              wstate_d  = W_IDLE;
              wr_done_d = 1'b1;
            end
          end
        end
`ifdef BRAM_SAMPLE_BUFFER_TRIG_EN
        W_RING: begin
          if (din_we) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
          // The trigger-cycle write is not part of the post-trigger count.
          if (trig) begin
            trig_addr_d = wr_ptr_q;
            wcnt_d      = clamp_len(post_len);
            if (clamp_len(post_len) == '0) begin
              wstate_d  = W_IDLE;
              wr_done_d = 1'b1;
            end else begin
              wstate_d = W_CAPT;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    rstate_d  = rstate_q;
    rd_ptr_d  = rd_ptr_q;
    rcnt_d    = rcnt_q;
    rd_done_d = rd_done_q;
    issue     = 1'b0;
    // A simultaneous capture start takes priority over playback.
    rd_accept = rd_start && (rstate_q == R_IDLE) && (wstate_q == W_IDLE) && !wr_start;
    err_d     = rd_start && !rd_accept;
    case (rstate_q)
      R_IDLE: begin
        if (rd_accept) begin
          rd_ptr_d  = rd_addr;
          rcnt_d    = clamp_len(rd_len);
          rd_done_d = (clamp_len(rd_len) == '0);
          if (clamp_len(rd_len) != '0) rstate_d = R_RUN;
        end
      end
      R_RUN: begin
        if (rd_ready) begin
          issue    = 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
          rcnt_d   = rcnt_q - 1'b1;
          if (rcnt_q == ONE_L) rstate_d = R_DRAIN;
        end
      end
      R_DRAIN: begin
        if (rd_ready && vld_p2_q && !vld_p1_q) begin
          rstate_d  = R_IDLE;
          rd_done_d = 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wstate_q    <= W_IDLE;
      wr_ptr_q    <= '0;
      wcnt_q      <= '0;
      wr_done_q   <= 1'b0;
      trig_addr_q <= '0;
      rstate_q    <= R_IDLE;
      rd_ptr_q    <= '0;
      rcnt_q      <= '0;
      rd_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wstate_q    <= wstate_d;
      wr_ptr_q    <= wr_ptr_d;
      wcnt_q      <= wcnt_d;
      wr_done_q   <= wr_done_d;
      trig_addr_q <= trig_addr_d;
      rstate_q    <= rstate_d;
      rd_ptr_q    <= rd_ptr_d;
      rcnt_q      <= rcnt_d;
      rd_done_q   <= rd_done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= din;
  end

  // Stage p1: BRAM read register
  always_ff @(posedge clk) begin
    if (issue) rdata_p1_q <= mem[rd_ptr_q];
  end

  // Stage p2: output register, frozen together with p1 while rd_ready is low
  always_ff @(posedge clk) begin
    if (rd_ready) dout_p2_q <= rdata_p1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else if (rd_ready) begin
      vld_p1_q <= issue;
      vld_p2_q <= vld_p1_q;
    end
  end

  assign dout       = dout_p2_q & {DATA_W{vld_p2_q}};
  assign dout_valid = vld_p2_q;
  assign wr_busy    = (wstate_q != W_IDLE);
  assign wr_done    = wr_done_q;
  assign rd_busy    = (rstate_q != R_IDLE);
  assign rd_done    = rd_done_q;
  assign err_reject = err_q;

endmodule

// File: tb/tb_bram_sample_buffer.sv
// Directed bench for bram_sample_buffer: capture, playback, wrap, backpressure, rejects, clamps.
module tb_bram_sample_buffer;

  localparam int CH    = 2;
  localparam int SW    = 8;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DW    = CH * SW;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] din;
  logic          din_we, wr_start, wr_busy, wr_done;
  logic [AW:0]   wr_len, rd_len;
  logic          rd_start, rd_ready, dout_valid, rd_busy, rd_done, err_reject;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] dout;
`ifdef BRAM_SAMPLE_BUFFER_TRIG_EN
  logic          trig_mode, trig;
  logic [AW:0]   post_len;
  logic [AW-1:0] trig_addr;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] got[$];

  bram_sample_buffer #(.CHANNELS(CH), .SAMPLE_W(SW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .din(din), .din_we(din_we),
    .wr_start(wr_start), .wr_len(wr_len), .wr_busy(wr_busy), .wr_done(wr_done),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ready(rd_ready),
    .dout(dout), .dout_valid(dout_valid), .rd_busy(rd_busy), .rd_done(rd_done),
`ifdef BRAM_SAMPLE_BUFFER_TRIG_EN
    .trig_mode(trig_mode), .trig(trig), .post_len(post_len), .trig_addr(trig_addr),
`endif
    .err_reject(err_reject)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int len, input int base, input int gap, output bit busy_ok);
    int n;
    wr_len = (AW+1)'(len);
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    busy_ok = (wr_busy === 1'b1);
    n = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < n; i++) begin
      repeat (gap - 1) tick();
      din = DW'(base + i);
      din_we = 1'b1;
      tick();
      din_we = 1'b0;
      if (i < n - 1 && wr_busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  // mode 0: rd_ready held high; mode 1: rd_ready alternates 1,0,1,0
  task automatic do_read(input int addr, input int len, input int mode,
                         output int lat, output int ncyc, output int hold_err, output bit tmo);
    logic [DW-1:0] held;
    bit held_pend, rdy, fin;
    int n;
    got.delete();
    lat = -1; hold_err = 0; held_pend = 0; fin = 0; n = 0; held = '0;
    rd_addr = AW'(addr);
    rd_len = (AW+1)'(len);
    rd_ready = 1'b1;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    while (!fin && n < 300) begin
      if (rd_done === 1'b1) begin
        fin = 1;
      end else begin
        if (dout_valid === 1'b1 && lat < 0) lat = n;
        if (held_pend) begin
          if (dout_valid !== 1'b1 || dout !== held) hold_err++;
          held_pend = 0;
        end
        rdy = (mode == 0) ? 1'b1 : (n % 2 == 0);
        rd_ready = rdy;
        if (dout_valid === 1'b1) begin
          if (rdy) got.push_back(dout);
          else begin held = dout; held_pend = 1; end
        end
        tick();
        n++;
      end
    end
    ncyc = n;
    tmo = !fin;
    rd_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    vectors++;
    if ({wr_busy, wr_done, rd_busy, rd_done, dout_valid, err_reject} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000000",
               {wr_busy, wr_done, rd_busy, rd_done, dout_valid, err_reject});
    end
    vectors++;
    if (dout !== '0) begin miscompares++; $display("FAIL reset_dout: got %0h expected 0", dout); end
`ifdef BRAM_SAMPLE_BUFFER_TRIG_EN
    vectors++;
    if (trig_addr !== '0) begin miscompares++; $display("FAIL reset_trig_addr: got %0d expected 0", trig_addr); end
`endif
  endtask

  task automatic test_write_read();
    bit bok, tmo;
    int lat, ncyc, herr;
    capture(32, 0, 8, bok);
    vectors++;
    if (bok !== 1'b1) begin miscompares++; $display("FAIL wr_busy_during_capt: got %0d expected 1", bok); end
    vectors++;
    if ({wr_busy, wr_done} !== 2'b01) begin
      miscompares++; $display("FAIL wr_end_flags: got %b expected 01", {wr_busy, wr_done});
    end
    do_read(0, 32, 0, lat, ncyc, herr, tmo);
    vectors++;
    if (tmo) begin miscompares++; $display("FAIL read1_timeout: got timeout expected rd_done"); end
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL read1_latency: got %0d expected 2", lat); end
    vectors++;
    if (ncyc !== 34) begin miscompares++; $display("FAIL read1_done_cycle: got %0d expected 34", ncyc); end
    vectors++;
    if (got.size() !== 32) begin miscompares++; $display("FAIL read1_count: got %0d expected 32", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      vectors++;
      if (got[i] !== DW'(i)) begin miscompares++; $display("FAIL read1_word%0d: got %0d expected %0d", i, got[i], i); end
    end
    vectors++;
    if ({rd_busy, dout_valid} !== 2'b00) begin
      miscompares++; $display("FAIL read1_end_flags: got %b expected 00", {rd_busy, dout_valid});
    end
  endtask

  task automatic test_recapture();
    bit bok, tmo;
    int lat, ncyc, herr;
    capture(128, 100, 1, bok);
    vectors++;
    if (wr_done !== 1'b1) begin miscompares++; $display("FAIL recapt_done: got %0d expected 1", wr_done); end
    for (int a = 1; a <= 2; a++) begin
      do_read(a, 32, 0, lat, ncyc, herr, tmo);
      vectors++;
      if (got.size() !== 32 || tmo) begin
        miscompares++; $display("FAIL recapt_count_a%0d: got %0d expected 32", a, got.size());
      end
      for (int i = 0; i < got.size(); i++) begin
        vectors++;
        if (got[i] !== DW'(100 + a + i)) begin
          miscompares++; $display("FAIL recapt_a%0d_word%0d: got %0d expected %0d", a, i, got[i], 100 + a + i);
        end
      end
    end
  endtask

  task automatic test_wrap();
    bit bok, tmo;
    int lat, ncyc, herr;
    int exp_w[8] = '{1020, 1021, 1022, 1023, 0, 1, 2, 3};
    capture(1024, 0, 1, bok);
    do_read(1020, 8, 0, lat, ncyc, herr, tmo);
    vectors++;
    if (got.size() !== 8 || tmo) begin miscompares++; $display("FAIL wrap_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      vectors++;
      if (got[i] !== DW'(exp_w[i])) begin
        miscompares++; $display("FAIL wrap_word%0d: got %0d expected %0d", i, got[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit tmo;
    int lat, ncyc, herr;
    do_read(10, 16, 1, lat, ncyc, herr, tmo);
    vectors++;
    if (tmo) begin miscompares++; $display("FAIL bp_timeout: got timeout expected rd_done"); end
    vectors++;
    if (herr !== 0) begin miscompares++; $display("FAIL bp_hold: got %0d unstable holds expected 0", herr); end
    vectors++;
    if (got.size() !== 16) begin miscompares++; $display("FAIL bp_count: got %0d expected 16", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      vectors++;
      if (got[i] !== DW'(10 + i)) begin miscompares++; $display("FAIL bp_word%0d: got %0d expected %0d", i, got[i], 10 + i); end
    end
  endtask

  task automatic test_rejects();
    int n;
    // rd_start while capturing
    wr_len = (AW+1)'(4);
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    rd_addr = '0; rd_len = (AW+1)'(4); rd_ready = 1'b1;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    vectors++;
    if ({err_reject, rd_busy} !== 2'b10) begin
      miscompares++; $display("FAIL rej_wrbusy: got err/busy %b expected 10", {err_reject, rd_busy});
    end
    tick();
    vectors++;
    if ({err_reject, rd_busy, dout_valid} !== 3'b000) begin
      miscompares++; $display("FAIL rej_pulse_end: got %b expected 000", {err_reject, rd_busy, dout_valid});
    end
    for (int i = 0; i < 4; i++) begin din = DW'(i); din_we = 1'b1; tick(); end
    din_we = 1'b0;
    // simultaneous starts with zero-length capture
    wr_len = '0; rd_len = (AW+1)'(4);
    wr_start = 1'b1; rd_start = 1'b1;
    tick();
    wr_start = 1'b0; rd_start = 1'b0;
    vectors++;
    if ({err_reject, wr_done, wr_busy, rd_busy} !== 4'b1100) begin
      miscompares++; $display("FAIL rej_same_cycle: got %b expected 1100", {err_reject, wr_done, wr_busy, rd_busy});
    end
    // rd_start while a read is running
    rd_ready = 1'b0; rd_len = (AW+1)'(8);
    rd_start = 1'b1;
    tick();
    tick();
    rd_start = 1'b0;
    vectors++;
    if ({err_reject, rd_busy, dout_valid} !== 3'b110) begin
      miscompares++; $display("FAIL rej_rdbusy: got %b expected 110", {err_reject, rd_busy, dout_valid});
    end
    rd_ready = 1'b1;
    n = 0;
    while (rd_done !== 1'b1 && n < 50) begin tick(); n++; end
    vectors++;
    if (rd_done !== 1'b1) begin miscompares++; $display("FAIL rej_drain_timeout: got rd_done %0d expected 1", rd_done); end
    // zero-length read
    rd_len = '0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    vectors++;
    if ({rd_done, rd_busy, dout_valid, err_reject} !== 4'b1000) begin
      miscompares++; $display("FAIL rdlen0: got %b expected 1000", {rd_done, rd_busy, dout_valid, err_reject});
    end
  endtask

  task automatic test_clamp();
    int first;
    bit tmo;
    int lat, ncyc, herr;
    wr_len = (AW+1)'(2000);
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    first = -1;
    for (int i = 0; i < 1100; i++) begin
      din = DW'(5000 + i);
      din_we = 1'b1;
      tick();
      if (first < 0 && wr_done === 1'b1) first = i + 1;
    end
    din_we = 1'b0;
    vectors++;
    if (first !== 1024) begin miscompares++; $display("FAIL clamp_writes: got %0d expected 1024", first); end
    do_read(1023, 2, 0, lat, ncyc, herr, tmo);
    vectors++;
    if (got.size() !== 2 || tmo) begin miscompares++; $display("FAIL clamp_rd_count: got %0d expected 2", got.size()); end
    else begin
      vectors++;
      if (got[0] !== DW'(6023)) begin miscompares++; $display("FAIL clamp_last: got %0d expected 6023", got[0]); end
      vectors++;
      if (got[1] !== DW'(5000)) begin miscompares++; $display("FAIL clamp_first: got %0d expected 5000", got[1]); end
    end
  endtask

`ifdef BRAM_SAMPLE_BUFFER_TRIG_EN
  task automatic test_trigger();
    int post;
    bit tmo;
    int lat, ncyc, herr;
    trig_mode = 1'b1; post_len = (AW+1)'(100); wr_len = '0;
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0; trig_mode = 1'b0;
    vectors++;
    if ({wr_busy, wr_done} !== 2'b10) begin miscompares++; $display("FAIL ring_busy: got %b expected 10", {wr_busy, wr_done}); end
    for (int i = 0; i <= 1724; i++) begin
      din = DW'(30000 + i); din_we = 1'b1; trig = (i == 1724);
      tick();
    end
    trig = 1'b0;
    vectors++;
    if (trig_addr !== AW'(700)) begin miscompares++; $display("FAIL trig_addr: got %0d expected 700", trig_addr); end
    post = -1;
    for (int k = 1; k <= 120; k++) begin
      din = DW'(30000 + 1724 + k); din_we = 1'b1; trig = (k == 5);
      tick();
      if (post < 0 && wr_done === 1'b1) post = k;
    end
    din_we = 1'b0; trig = 1'b0;
    vectors++;
    if (post !== 100) begin miscompares++; $display("FAIL trig_post_writes: got %0d expected 100", post); end
    vectors++;
    if (trig_addr !== AW'(700)) begin miscompares++; $display("FAIL trig_addr_hold: got %0d expected 700", trig_addr); end
    do_read(800, 2, 0, lat, ncyc, herr, tmo);
    vectors++;
    if (got.size() !== 2 || tmo) begin miscompares++; $display("FAIL trig_rd_count: got %0d expected 2", got.size()); end
    else begin
      vectors++;
      if (got[0] !== DW'(31824)) begin miscompares++; $display("FAIL trig_last_write: got %0d expected 31824", got[0]); end
      vectors++;
      if (got[1] !== DW'(30801)) begin miscompares++; $display("FAIL trig_after_last: got %0d expected 30801", got[1]); end
    end
  endtask
`endif

  task automatic test_reset_midop();
    wr_len = (AW+1)'(10);
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    din_we = 1'b1;
    repeat (3) tick();
    din_we = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({wr_busy, wr_done} !== 2'b00) begin miscompares++; $display("FAIL midop_wr: got %b expected 00", {wr_busy, wr_done}); end
    rd_addr = '0; rd_len = (AW+1)'(8); rd_ready = 1'b1;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({rd_busy, rd_done, dout_valid, err_reject} !== 4'b0000) begin
      miscompares++; $display("FAIL midop_rd: got %b expected 0000", {rd_busy, rd_done, dout_valid, err_reject});
    end
  endtask

  initial begin
    reset = 1'b1; din = '0; din_we = 1'b0; wr_start = 1'b0; wr_len = '0;
    rd_start = 1'b0; rd_addr = '0; rd_len = '0; rd_ready = 1'b1;
`ifdef BRAM_SAMPLE_BUFFER_TRIG_EN
    trig_mode = 1'b0; trig = 1'b0; post_len = '0;
`endif
    test_reset();
    test_write_read();
    test_recapture();
    test_wrap();
    test_backpressure();
    test_rejects();
    test_clamp();
`ifdef BRAM_SAMPLE_BUFFER_TRIG_EN
    test_trigger();
`endif
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
